// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared types for the L1 cache / physical-memory arbiter.
//               arb_state_t - arbiter FSM states
//               arb_owner_t - which L1 cache owns the memory port
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : cache_arb_pick
// Description : Combinational winner select between the I-cache and D-cache
//               memory requests.
// Ports       : i_req_i    - I-cache requesting
//               d_req_i    - D-cache requesting
//               rr_ptr_i   - 1: prefer I on contention, 0: prefer D
//                            (tied 0 for fixed D-over-I priority)
//               grant_o    - some request is present
//               winner_o   - owner to grant when grant_o is high
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arb_pick
  import rv32i_types::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic       rr_ptr_i,
  output logic       grant_o,
  output arb_owner_t winner_o
);

  assign grant_o = i_req_i | d_req_i;

  // D wins if it is the only requester, or on contention when the pointer
  // does not favour I.
  assign winner_o = (d_req_i && (!i_req_i || !rr_ptr_i)) ? ARB_D : ARB_I;

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares the single physical-memory burst port between the
//               I-cache (line fills) and D-cache (fills and writebacks).
//               One request is latched, driven to memory, the response is
//               returned to its owner, then a one-cycle release bubble lets
//               the owner drop its request before the next grant.
// Config      : CACHE_ARB_RR_EN - when defined, contention is resolved
//               round-robin (1-bit pointer); otherwise fixed D-over-I.
// Ports       : clk, rst (async, active-high)
//               i_pmem_read/addr -> i_pmem_rdata/resp   I-cache side
//               d_pmem_read/write/addr/wdata -> d_pmem_rdata/resp  D-cache
//               mem_read/write/addr/wdata <- mem_rdata/resp        memory
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_addr,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_addr,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_q,    rd_d;
  logic                  wr_q,    wr_d;

  logic                  w_d_req;
  logic                  w_grant;
  arb_owner_t            w_winner;
  logic                  w_rr_ptr;

  assign w_d_req = d_pmem_read | d_pmem_write;

`ifdef CACHE_ARB_RR_EN
  // Points at the side NOT granted last: 1 = prefer I, 0 = prefer D.
  logic rr_q, rr_d;
  assign w_rr_ptr = rr_q;
`else
  assign w_rr_ptr = 1'b0;
`endif

  cache_arb_pick u_pick (
    .i_req_i  (i_pmem_read),
    .d_req_i  (w_d_req),
    .rr_ptr_i (w_rr_ptr),
    .grant_o  (w_grant),
    .winner_o (w_winner)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
`ifdef CACHE_ARB_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (w_grant) begin
          if (w_winner == ARB_D) begin
            state_d = SERVE_D;
            addr_d  = d_pmem_addr;
            wdata_d = d_pmem_wdata;
            // Read and write together is treated as a writeback.
            wr_d    = d_pmem_write;
            rd_d    = ~d_pmem_write;
          end else begin
            state_d = SERVE_I;
            addr_d  = i_pmem_addr;
            wr_d    = 1'b0;
            rd_d    = 1'b1;
          end
`ifdef CACHE_ARB_RR_EN
          rr_d = (w_winner == ARB_D);
`endif
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_d = RELEASE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
`ifdef CACHE_ARB_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
`ifdef CACHE_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Memory side is driven purely from the latched transaction.
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Read data is broadcast; only the completion pulse is steered.
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign i_pmem_resp  = (state_q == SERVE_I) & mem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & mem_resp;

`ifndef SYNTHESIS
  a_d_rw_exclusive : assert property (@(posedge clk) disable iff (rst)
      !(d_pmem_read && d_pmem_write))
    else $warning("d_pmem_read and d_pmem_write both high; treated as write");
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Scoreboard bench for cache_mem_arbiter. Directed stimulus
//               pushes expected grants/responses into queues; a monitor on
//               the falling edge pops and compares when the DUT shows them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_addr;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_addr;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pmem_read  (i_pmem_read),
    .i_pmem_addr  (i_pmem_addr),
    .i_pmem_rdata (i_pmem_rdata),
    .i_pmem_resp  (i_pmem_resp),
    .d_pmem_read  (d_pmem_read),
    .d_pmem_write (d_pmem_write),
    .d_pmem_addr  (d_pmem_addr),
    .d_pmem_wdata (d_pmem_wdata),
    .d_pmem_rdata (d_pmem_rdata),
    .d_pmem_resp  (d_pmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } grant_t;

  typedef struct {
    logic          is_d;
    logic [LW-1:0] rdata;
  } resp_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];

  int n_vec  = 0;
  int n_miss = 0;
  bit rr_m   = 1'b0;  // model pointer: 1 = prefer I on contention

  localparam logic [LW-1:0] RD_AA = {32{8'hAA}};
  localparam logic [LW-1:0] RD_55 = {32{8'h55}};
  localparam logic [LW-1:0] RD_C3 = {32{8'hC3}};
  localparam logic [LW-1:0] RD_0F = {32{8'h0F}};
  localparam logic [LW-1:0] WD_1  = {8{32'h1234_5678}};
  localparam logic [LW-1:0] WD_2  = {8{32'hDEAD_BEEF}};

  task automatic chk(input string name, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input bit is_d, input bit wr, input logic [AW-1:0] a,
                               input logic [LW-1:0] wd, input logic [LW-1:0] rd,
                               input bit will_resp);
    grant_t g;
    resp_t  r;
    g.rd = !wr; g.wr = wr; g.addr = a; g.wdata = wd;
    grant_q.push_back(g);
    if (will_resp) begin
      r.is_d = is_d; r.rdata = rd;
      resp_q.push_back(r);
    end
`ifdef CACHE_ARB_RR_EN
    rr_m = is_d;
`endif
  endfunction

  // ---------------------------------------------------------------- monitor
  grant_t m_cur;
  resp_t  m_r;
  logic   m_strobe;
  logic   m_prev_strobe = 1'b0;
  logic   m_prev_resp   = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_prev_strobe = 1'b0;
      m_prev_resp   = 1'b0;
    end else begin
      m_strobe = mem_read | mem_write;
      if (m_prev_resp) chk("release_gap_strobe", m_strobe, 0);
      if (m_strobe && !m_prev_strobe) begin
        if (grant_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_grant: got addr %0h expected none", mem_addr);
        end else begin
          m_cur = grant_q.pop_front();
          chk("grant_mem_read",  mem_read,  m_cur.rd);
          chk("grant_mem_write", mem_write, m_cur.wr);
          chk("grant_mem_addr",  mem_addr,  m_cur.addr);
          if (m_cur.wr) chk("grant_mem_wdata", mem_wdata, m_cur.wdata);
        end
      end else if (m_strobe) begin
        chk("addr_hold", mem_addr, m_cur.addr);
        if (m_cur.wr) chk("wdata_hold", mem_wdata, m_cur.wdata);
      end
      if (i_pmem_resp || d_pmem_resp) begin
        if (resp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_resp: got i=%0b d=%0b expected none",
                   i_pmem_resp, d_pmem_resp);
        end else begin
          m_r = resp_q.pop_front();
          chk("resp_i", i_pmem_resp, !m_r.is_d);
          chk("resp_d", d_pmem_resp, m_r.is_d);
          chk("rdata_i", i_pmem_rdata, m_r.rdata);
          chk("rdata_d", d_pmem_rdata, m_r.rdata);
        end
      end
      m_prev_strobe = m_strobe;
      m_prev_resp   = i_pmem_resp | d_pmem_resp;
    end
  end

  // ----------------------------------------------------------------- driver
  task automatic wait_strobe(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (mem_read | mem_write) begin
        ok = 1'b1;
        return;
      end
    end
    n_vec++; n_miss++;
    $display("FAIL strobe_timeout: got no strobe expected strobe within 20 cycles");
  endtask

  // Entered at the falling edge of the first strobe cycle; completes in cycle n.
  task automatic respond(input int n, input logic [LW-1:0] rd, input int hold,
                         input bit own_d);
    for (int c = 1; c < n; c++) begin
      @(posedge clk); #1;
      chk("strobe_held", mem_read | mem_write, 1);
    end
    mem_resp  = 1'b1;
    mem_rdata = rd;
    @(posedge clk); #1;
    if (own_d) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
    else       i_pmem_read = 1'b0;
    if (hold > 1) begin
      @(negedge clk);
      chk("release_resp_i", i_pmem_resp, 0);
      chk("release_resp_d", d_pmem_resp, 0);
      @(posedge clk); #1;
    end
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic single(input bit is_d, input bit wr, input logic [AW-1:0] a,
                        input logic [LW-1:0] wd, input logic [LW-1:0] rd,
                        input int n, input int hold);
    int lat;
    bit ok;
    push(is_d, wr, a, wd, rd, 1'b1);
    @(posedge clk); #1;
    if (is_d) begin
      d_pmem_read = !wr; d_pmem_write = wr; d_pmem_addr = a; d_pmem_wdata = wd;
    end else begin
      i_pmem_read = 1'b1; i_pmem_addr = a;
    end
    wait_strobe(lat, ok);
    if (ok) begin
      chk("grant_latency", lat, 2);
      respond(n, rd, hold, is_d);
    end
  endtask

  task automatic contend(input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input bit dwr, input logic [LW-1:0] wd,
                         input logic [LW-1:0] rdi, input logic [LW-1:0] rdd);
    int lat;
    bit ok;
    bit first_d;
    first_d = !rr_m;
    if (first_d) begin
      push(1'b1, dwr, da, wd, rdd, 1'b1);
      push(1'b0, 1'b0, ia, '0, rdi, 1'b1);
    end else begin
      push(1'b0, 1'b0, ia, '0, rdi, 1'b1);
      push(1'b1, dwr, da, wd, rdd, 1'b1);
    end
    @(posedge clk); #1;
    i_pmem_read = 1'b1; i_pmem_addr = ia;
    d_pmem_read = !dwr; d_pmem_write = dwr; d_pmem_addr = da; d_pmem_wdata = wd;
    for (int k = 0; k < 2; k++) begin
      bit own_d;
      own_d = (k == 0) ? first_d : !first_d;
      wait_strobe(lat, ok);
      if (!ok) return;
      respond(3, own_d ? rdd : rdi, 1, own_d);
    end
  endtask

  initial begin
    int lat;
    bit ok;
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_addr = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_addr = '0; d_pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read",  mem_read,  0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_resp",    i_pmem_resp, 0);
    chk("rst_d_resp",    d_pmem_resp, 0);
    @(posedge clk); #1 rst = 1'b0;

    // I-cache fill, memory answers in the 4th strobe cycle
    single(1'b0, 1'b0, 32'h0000_0060, '0, RD_AA, 4, 1);
    // D-cache writeback; mem_resp held into the release cycle
    single(1'b1, 1'b1, 32'h8000_0020, WD_1, RD_55, 3, 2);

    // Spurious mem_resp while idle
    @(posedge clk); #1;
    mem_resp = 1'b1; mem_rdata = RD_C3;
    @(negedge clk);
    chk("spurious_i_resp", i_pmem_resp, 0);
    chk("spurious_d_resp", d_pmem_resp, 0);
    chk("spurious_strobe", mem_read | mem_write, 0);
    @(posedge clk); #1;
    mem_resp = 1'b0; mem_rdata = '0;
    single(1'b0, 1'b0, 32'h0000_0080, '0, RD_0F, 2, 1);

    // Contention, twice
    contend(32'h0000_1000, 32'h0000_2000, 1'b0, '0, RD_AA, RD_55);
    contend(32'h0000_3000, 32'h0000_4000, 1'b1, WD_2, RD_C3, RD_0F);

    // D request address changes while being served
    push(1'b1, 1'b0, 32'h0000_0100, '0, RD_C3, 1'b1);
    @(posedge clk); #1;
    d_pmem_read = 1'b1; d_pmem_addr = 32'h0000_0100;
    wait_strobe(lat, ok);
    if (ok) begin
      d_pmem_addr = 32'h0000_0200;
      respond(3, RD_C3, 1, 1'b1);
    end

    // Reset during an I fill
    push(1'b0, 1'b0, 32'h0000_0140, '0, '0, 1'b0);
    @(posedge clk); #1;
    i_pmem_read = 1'b1; i_pmem_addr = 32'h0000_0140;
    wait_strobe(lat, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_mem_read", mem_read, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_i_resp",   i_pmem_resp, 0);
    i_pmem_read = 1'b0;
    rr_m = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    single(1'b0, 1'b0, 32'h0000_0180, '0, RD_55, 3, 1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("grant_q_empty", grant_q.size(), 0);
    chk("resp_q_empty",  resp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
